ly_2257_4: RTL and testbench
============================

LY_2257_4 -- requirements
Module: ly_2257_4

Interface
REQ-001 Parameter DIV1, default 2257: divide ratio of channel 1; legal range 2..65535.
REQ-002 Parameter DIV2, default 4: divide ratio of channel 2; legal range 2..65535.
REQ-003 clk_in  input  1: single system clock; all flops rise-edge triggered on clk_in.
REQ-004 rst_n  input  1: reset, asynchronous, active-high (asserted at 1); the name rst_n is kept for codebase compatibility and does not mean active-low.
REQ-005 sel  input  1: output select, asynchronous to nothing in particular; 1 selects channel 1, 0 selects channel 2.
REQ-006 clk_out  output  1: selected divided clock, registered.
REQ-007 CO1  output  16: channel-1 counter value.
REQ-008 CO2  output  16: channel-2 counter value.
REQ-009 out1  output  1: channel-1 divided clock, registered.
REQ-010 out2  output  1: channel-2 divided clock, registered.

Function
REQ-011 Each channel x (1,2) SHALL have a 16-bit counter COx that increments by 1 per clk_in rising edge and wraps from DIVx-1 to 0.
REQ-012 Both counters SHALL free-run continuously, independent of sel; a change of sel SHALL NOT reset or stall either counter.
REQ-013 outx SHALL equal 1 exactly when COx >= ceil(DIVx/2), i.e. low for ceil(DIVx/2) cycles, then high for floor(DIVx/2) cycles, per period.
REQ-014 outx SHALL be a flop updated on the same edge as COx, with no combinational path from counter to port.
REQ-015 Period of outx SHALL be exactly DIVx clk_in cycles; for DIV1=2257: 1129 cycles low, 1128 high; for DIV2=4: 2 low, 2 high.
REQ-016 sel SHALL pass through a 2-flop synchronizer (sel_s) before use.
REQ-017 clk_out SHALL be registered as sel_s ? out1 : out2 each cycle, giving clk_out = selected outx delayed by 1 cycle.
REQ-018 A sel transition SHALL be reflected on the clk_out source no later than 3 clk_in edges after it is sampled; a clk_out pulse shortened at the switch point is permitted.
REQ-019 Counter arithmetic SHALL be 16-bit unsigned; no value >= DIVx SHALL ever appear on COx.

Reset
REQ-020 While rst_n=1: CO1=0, CO2=0, out1=0, out2=0, clk_out=0, both synchronizer flops=0, applied asynchronously.
REQ-021 On deassertion, the first rising edge SHALL produce CO1=1 and CO2=1; reset asserted mid-period SHALL restart both channels from count 0.

Structure
REQ-022 Package ly_2257_4_pkg SHALL hold CNT_W=16 and the default ratios 2257 and 4.
REQ-023 One sub-module, clk_div_cnt (parameter DIV; ports clk_in, rst_n, cnt[15:0], div_out), SHALL be instantiated twice; the synchronizer and output mux reside in the top level.

Verification
REQ-024 Reset held 50 ns at 50 MHz, then released -> all outputs 0 during reset; CO1 and CO2 read 1 after the first edge.
REQ-025 sel=1 for 400 us -> out1 period 2257 cycles (45.14 us), 1129 low/1128 high; clk_out tracks out1 delayed by 1 cycle.
REQ-026 sel switched 1->0 -> within 3 edges clk_out follows out2 with period 4 (2 low/2 high); CO1 continues counting without interruption.
REQ-027 CO1 at 2256 -> next edge 0; CO2 at 3 -> next edge 0; out1 rises at CO1=1129.
REQ-028 rst_n pulsed mid-period with CO1=1500 -> CO1, out1 and clk_out immediately 0, with no wait for a clock edge.
REQ-029 DIV1=3 and DIV2=2 override -> out1 has 2 cycles low, 1 high; out2 toggles every cycle.

Source files
------------

// File: rtl/ly_2257_4_pkg.sv
// Shared widths, default divide ratios and the duty-cycle threshold helper
// for the dual clock divider.
package ly_2257_4_pkg;
   localparam int CNT_W        = 16;
   localparam int DIV1_DEFAULT = 2257;
   localparam int DIV2_DEFAULT = 4;

   // First count value at which the divided clock is high: ceil(div/2).
   function automatic int high_threshold(input int div);
      return (div + 1) / 2;
   endfunction
endpackage

// File: rtl/clk_div_cnt.sv
// Free-running modulo-DIV counter with a registered divided clock that is low
// for ceil(DIV/2) cycles and high for floor(DIV/2) cycles.
module clk_div_cnt
   import ly_2257_4_pkg::*;
#(
   parameter int DIV = DIV2_DEFAULT
) (
   input  logic             clk_in,
   input  logic             rst_n,
   output logic [CNT_W-1:0] cnt,
   output logic             div_out
);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] THRESH = CNT_W'(high_threshold(DIV));

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;

   // The output compares the next count so it changes on the same edge as cnt.
   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      out_d = (cnt_d >= THRESH);
   end

   always_ff @(posedge clk_in or posedge rst_n) begin
      if (rst_n) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign cnt     = cnt_q;
   assign div_out = out_q;
endmodule

// File: rtl/ly_2257_4.sv
// Two independent clock dividers with a synchronized select choosing which
// divided clock drives the registered clk_out.
module ly_2257_4
   import ly_2257_4_pkg::*;
#(
   parameter int DIV1 = DIV1_DEFAULT,
   parameter int DIV2 = DIV2_DEFAULT
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             sel,
   output logic             clk_out,
   output logic [CNT_W-1:0] CO1,
   output logic [CNT_W-1:0] CO2,
   output logic             out1,
   output logic             out2
);
   logic sel_meta_q, sel_s_q;
   logic clk_out_q, clk_out_d;

   clk_div_cnt #(.DIV(DIV1)) u_ch1 (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .cnt     (CO1),
      .div_out (out1)
   );

   clk_div_cnt #(.DIV(DIV2)) u_ch2 (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .cnt     (CO2),
      .div_out (out2)
   );

   // sel has no defined timing relation to clk_in, so it is double-flopped.
   assign clk_out_d = sel_s_q ? out1 : out2;

   always_ff @(posedge clk_in or posedge rst_n) begin
      if (rst_n) begin
         sel_meta_q <= 1'b0;
         sel_s_q    <= 1'b0;
         clk_out_q  <= 1'b0;
      end else begin
         sel_meta_q <= sel;
         sel_s_q    <= sel_meta_q;
         clk_out_q  <= clk_out_d;
      end
   end

   assign clk_out = clk_out_q;
endmodule

// File: tb/tb_ly_2257_4.sv
// Randomized self-checking bench: a default instance and a DIV1=3/DIV2=2
// instance are compared every cycle against an arithmetic reference model.
module tb_ly_2257_4;
   logic        clk_in = 1'b0;
   logic        rst_n  = 1'b1;
   logic        sel    = 1'b0;
   logic        clk_a, out1_a, out2_a, clk_b, out1_b, out2_b;
   logic [15:0] co1_a, co2_a, co1_b, co2_b;

   int tests = 0;
   int fails = 0;
   int n     = 0;          // rising edges since reset release
   bit sel_hist [0:65535]; // sel value sampled at edge k

   always #10 clk_in = ~clk_in;

   ly_2257_4 dut_a (
      .clk_in(clk_in), .rst_n(rst_n), .sel(sel), .clk_out(clk_a),
      .CO1(co1_a), .CO2(co2_a), .out1(out1_a), .out2(out2_a)
   );

   ly_2257_4 #(.DIV1(3), .DIV2(2)) dut_b (
      .clk_in(clk_in), .rst_n(rst_n), .sel(sel), .clk_out(clk_b),
      .CO1(co1_b), .CO2(co2_b), .out1(out1_b), .out2(out2_b)
   );

   function automatic bit ref_out(input int k, input int div);
      return (k % div) >= ((div + 1) / 2);
   endfunction

   // {clk_out, out1, out2, CO1, CO2} expected after edge k.
   function automatic logic [34:0] ref_vec(input int k, input int d1, input int d2);
      bit s, c;
      s = (k - 2 >= 1) ? sel_hist[k-2] : 1'b0;
      c = (k >= 1) ? (s ? ref_out(k - 1, d1) : ref_out(k - 1, d2)) : 1'b0;
      return {c, ref_out(k, d1), ref_out(k, d2), 16'(k % d1), 16'(k % d2)};
   endfunction

   task automatic tick();
      if (n + 1 <= 65535) sel_hist[n+1] = sel;
      @(posedge clk_in);
      #2;
      n++;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (3) @(posedge clk_in);
      #2;
      tests++;
      if ({clk_a, out1_a, out2_a, co1_a, co2_a} !== 35'd0) begin
         fails++;
         $display("FAIL reset_a got=%h exp=0", {clk_a, out1_a, out2_a, co1_a, co2_a});
      end
      tests++;
      if ({clk_b, out1_b, out2_b, co1_b, co2_b} !== 35'd0) begin
         fails++;
         $display("FAIL reset_b got=%h exp=0", {clk_b, out1_b, out2_b, co1_b, co2_b});
      end
      rst_n = 1'b0;
      n     = 0;
      tick();
      tests++;
      if (co1_a !== 16'd1 || co2_a !== 16'd1) begin
         fails++;
         $display("FAIL first_edge CO1=%0d CO2=%0d exp=1,1", co1_a, co2_a);
      end
   endtask

   task automatic test_sel1_period();
      int run, last_low, last_high;
      bit prev;
      sel = 1'b1;
      run = 0; last_low = 0; last_high = 0; prev = out1_a;
      for (int i = 0; i < 20000; i++) begin
         tick();
         tests++;
         if ({clk_a, out1_a, out2_a, co1_a, co2_a} !== ref_vec(n, 2257, 4)) begin
            fails++;
            $display("FAIL sel1_a n=%0d got=%h exp=%h", n,
                     {clk_a, out1_a, out2_a, co1_a, co2_a}, ref_vec(n, 2257, 4));
         end
         run++;
         if (out1_a !== prev) begin
            if (prev) last_high = run; else last_low = run;
            run  = 0;
            prev = out1_a;
         end
      end
      tests++;
      if (last_low != 1129 || last_high != 1128) begin
         fails++;
         $display("FAIL out1_duty low=%0d high=%0d exp=1129/1128", last_low, last_high);
      end
   endtask

   task automatic test_switch();
      sel = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         tests++;
         if ({clk_a, out1_a, out2_a, co1_a, co2_a} !== ref_vec(n, 2257, 4)) begin
            fails++;
            $display("FAIL switch_a n=%0d got=%h exp=%h", n,
                     {clk_a, out1_a, out2_a, co1_a, co2_a}, ref_vec(n, 2257, 4));
         end
         if (i >= 3) begin
            tests++;
            if (clk_a !== ref_out(n - 1, 4)) begin
               fails++;
               $display("FAIL switch_follow n=%0d got=%b exp=%b", n, clk_a, ref_out(n - 1, 4));
            end
         end
      end
   endtask

   task automatic test_random_sel();
      for (int i = 0; i < 3000; i++) begin
         tick();
         tests++;
         if ({clk_a, out1_a, out2_a, co1_a, co2_a} !== ref_vec(n, 2257, 4)) begin
            fails++;
            $display("FAIL rand_a n=%0d got=%h exp=%h", n,
                     {clk_a, out1_a, out2_a, co1_a, co2_a}, ref_vec(n, 2257, 4));
         end
         tests++;
         if ({clk_b, out1_b, out2_b, co1_b, co2_b} !== ref_vec(n, 3, 2)) begin
            fails++;
            $display("FAIL rand_b n=%0d got=%h exp=%h", n,
                     {clk_b, out1_b, out2_b, co1_b, co2_b}, ref_vec(n, 3, 2));
         end
         if ($urandom_range(0, 15) == 0) sel = ~sel;
      end
   endtask

   task automatic test_wrap();
      while ((n % 4) != 3) tick();
      tests++;
      if (co2_a !== 16'd3) begin fails++; $display("FAIL co2_top got=%0d exp=3", co2_a); end
      tick();
      tests++;
      if (co2_a !== 16'd0) begin fails++; $display("FAIL co2_wrap got=%0d exp=0", co2_a); end
      while ((n % 2257) != 1128) tick();
      tests++;
      if (out1_a !== 1'b0) begin fails++; $display("FAIL out1_pre got=%b exp=0", out1_a); end
      tick();
      tests++;
      if (co1_a !== 16'd1129 || out1_a !== 1'b1) begin
         fails++;
         $display("FAIL out1_rise CO1=%0d out1=%b exp=1129,1", co1_a, out1_a);
      end
      while ((n % 2257) != 2256) tick();
      tests++;
      if (co1_a !== 16'd2256) begin fails++; $display("FAIL co1_top got=%0d exp=2256", co1_a); end
      tick();
      tests++;
      if (co1_a !== 16'd0 || out1_a !== 1'b0) begin
         fails++;
         $display("FAIL co1_wrap CO1=%0d out1=%b exp=0,0", co1_a, out1_a);
      end
   endtask

   task automatic test_override();
      for (int i = 0; i < 9; i++) begin
         tick();
         tests++;
         if (out1_b !== ((n % 3) == 2) || out2_b !== ((n % 2) == 1)) begin
            fails++;
            $display("FAIL override n=%0d out1=%b out2=%b exp=%b,%b", n, out1_b, out2_b,
                     (n % 3) == 2, (n % 2) == 1);
         end
      end
   endtask

   task automatic test_async_reset();
      sel = 1'b1;
      while ((n % 2257) != 1500) tick();
      #5;
      rst_n = 1'b1;
      #1;
      tests++;
      if ({clk_a, out1_a, out2_a, co1_a, co2_a} !== 35'd0) begin
         fails++;
         $display("FAIL async_rst got=%h exp=0", {clk_a, out1_a, out2_a, co1_a, co2_a});
      end
      @(posedge clk_in);
      #2;
      rst_n = 1'b0;
      n     = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++;
         if ({clk_a, out1_a, out2_a, co1_a, co2_a} !== ref_vec(n, 2257, 4)) begin
            fails++;
            $display("FAIL restart_a n=%0d got=%h exp=%h", n,
                     {clk_a, out1_a, out2_a, co1_a, co2_a}, ref_vec(n, 2257, 4));
         end
      end
   endtask

   initial begin
      test_reset();
      test_sel1_period();
      test_switch();
      test_random_sel();
      test_wrap();
      test_override();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
